// File: rtl/fifo_request_serializer_if.sv
// -----------------------------------------------------------------------------
// fifo_request_serializer_if
//
// Bundles the FIFO-side pop handshake and the downstream beat handshake of
// fifo_request_serializer. Signal names keep the serializer's point of view,
// so *_in signals are driven by the environment and *_out signals by the
// serializer.
//
//   slave  modport : the serializer itself
//   master modport : FIFO + downstream link (or a testbench standing in)
//
// Signals:
//   request_in        entry presented by the FIFO (request_out)
//   request_valid_in  FIFO entry valid (request_valid_out)
//   issue_ack_out     one-cycle pop pulse back to the FIFO (issue_ack_in)
//   beat_out          current narrow beat, LSB slice of the entry first
//   beat_valid_out    beat valid
//   beat_last_out     final beat of the entry
//   beat_ready_in     downstream accepts the beat
//   busy_out          an entry is held
//   beat_parity_out   even parity of beat_out (SERIALIZER_BEAT_PARITY_EN only)
//
// Optional feature macro: SERIALIZER_BEAT_PARITY_EN
// -----------------------------------------------------------------------------
interface fifo_request_serializer_if #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int BEAT_WIDTH_IN_BITS         = 16
);

  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
  logic                                  request_valid_in;
  logic                                  issue_ack_out;
  logic [BEAT_WIDTH_IN_BITS-1:0]         beat_out;
  logic                                  beat_valid_out;
  logic                                  beat_last_out;
  logic                                  beat_ready_in;
  logic                                  busy_out;

`ifdef SERIALIZER_BEAT_PARITY_EN
  logic                                  beat_parity_out;

  modport slave (
    input  request_in,
    input  request_valid_in,
    output issue_ack_out,
    output beat_out,
    output beat_valid_out,
    output beat_last_out,
    input  beat_ready_in,
    output busy_out,
    output beat_parity_out
  );

  modport master (
    output request_in,
    output request_valid_in,
    input  issue_ack_out,
    input  beat_out,
    input  beat_valid_out,
    input  beat_last_out,
    output beat_ready_in,
    input  busy_out,
    input  beat_parity_out
  );
`else
  modport slave (
    input  request_in,
    input  request_valid_in,
    output issue_ack_out,
    output beat_out,
    output beat_valid_out,
    output beat_last_out,
    input  beat_ready_in,
    output busy_out
  );

  modport master (
    output request_in,
    output request_valid_in,
    input  issue_ack_out,
    input  beat_out,
    input  beat_valid_out,
    input  beat_last_out,
    output beat_ready_in,
    input  busy_out
  );
`endif

endinterface : fifo_request_serializer_if

// File: rtl/fifo_request_serializer.sv
// -----------------------------------------------------------------------------
// fifo_request_serializer
//
// Pops one wide entry from a request FIFO, acknowledges it with a registered
// one-cycle pulse, and replays it as NUM_BEATS narrow beats on a valid/ready
// link, least-significant slice first.
//
// Parameters:
//   SINGLE_ENTRY_WIDTH_IN_BITS  width of one popped entry (default 64)
//   BEAT_WIDTH_IN_BITS          width of one beat; must divide the entry width
//   NUM_BEATS                   beats per entry; must be >= 2
//   BEAT_CNT_WIDTH_IN_BITS      beat counter width
//
// Ports:
//   clk_in      single clock, all state on the rising edge
//   reset_n_in  asynchronous active-low reset
//   bus         fifo_request_serializer_if.slave (FIFO pop + beat handshake)
//
// Optional feature macro: SERIALIZER_BEAT_PARITY_EN adds bus.beat_parity_out,
// the even parity (XOR reduction) of beat_out, 0 whenever no beat is valid.
//
// All downstream outputs are decoded from registers only; beat_ready_in and
// request_valid_in only steer next state.
// -----------------------------------------------------------------------------
module fifo_request_serializer #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int BEAT_WIDTH_IN_BITS         = 16,
  parameter int NUM_BEATS                  = SINGLE_ENTRY_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS,
  parameter int BEAT_CNT_WIDTH_IN_BITS     = $clog2(NUM_BEATS)
) (
  input logic                      clk_in,
  input logic                      reset_n_in,
  fifo_request_serializer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef logic [BEAT_CNT_WIDTH_IN_BITS-1:0] beat_cnt_t;

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(NUM_BEATS - 1);

  // Two cycles of holdoff cover the ack cycle and the cycle after it, during
  // which the FIFO may still show the popped entry before its valid drops.
  localparam logic [1:0] HOLDOFF_INIT = 2'd2;

  state_e                                state_q,   state_d;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] shift_q,   shift_d;
  beat_cnt_t                             cnt_q,     cnt_d;
  logic [1:0]                            holdoff_q, holdoff_d;
  logic                                  ack_q,     ack_d;

  logic [BEAT_WIDTH_IN_BITS-1:0]         beat;
  logic                                  beat_valid;
  logic                                  beat_last;
  logic                                  busy;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the entry shift register is reset as well; a held entry must be
  // discarded so its remaining beats can never leak out after reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      holdoff_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      holdoff_q <= holdoff_d;
      ack_q     <= ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    holdoff_d  = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;

    beat       = '0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.request_valid_in && (holdoff_q == 2'd0)) begin
          shift_d   = bus.request_in;
          cnt_d     = '0;
          state_d   = SEND;
          ack_d     = 1'b1;
          holdoff_d = HOLDOFF_INIT;
        end
      end

      SEND: begin
        beat       = shift_q[BEAT_WIDTH_IN_BITS-1:0];
        beat_valid = 1'b1;
        beat_last  = (cnt_q == LAST_BEAT);
        busy       = 1'b1;

        if (bus.beat_ready_in) begin
          if (beat_last) begin
            // Final beat accepted: drop the entry and return to IDLE.
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            shift_d = shift_q >> BEAT_WIDTH_IN_BITS;
            cnt_d   = cnt_q + beat_cnt_t'(1);
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.issue_ack_out  = ack_q;
  assign bus.beat_out       = beat;
  assign bus.beat_valid_out = beat_valid;
  assign bus.beat_last_out  = beat_last;
  assign bus.busy_out       = busy;

`ifdef SERIALIZER_BEAT_PARITY_EN
  // beat is forced to zero outside SEND, so parity is 0 whenever not valid.
  assign bus.beat_parity_out = ^beat;
`endif

endmodule : fifo_request_serializer

// File: tb/tb_fifo_request_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_request_serializer
//
// Directed bench for fifo_request_serializer: a vector table for the single
// entry and backpressure cases, plus hand-written sequences for reset,
// back-to-back FIFO traffic, reset mid-entry and (optionally) beat parity.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_fifo_request_serializer;

  localparam int EW = 64;
  localparam int BW = 16;
  localparam int NB = EW / BW;

  typedef struct {
    logic          ready;
    logic          valid;
    logic [EW-1:0] req;
    logic [BW-1:0] beat;
    logic          bvalid;
    logic          last;
    logic          ack;
    logic          busy;
  } vec_t;

  localparam logic [EW-1:0] ENTRY_E = 64'h0123_4567_89AB_CDEF;
  localparam logic [EW-1:0] ENTRY_X = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_request_serializer_if #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(EW),
    .BEAT_WIDTH_IN_BITS        (BW)
  ) bus_if ();

  fifo_request_serializer #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(EW),
    .BEAT_WIDTH_IN_BITS        (BW)
  ) dut (
    .clk_in    (clk),
    .reset_n_in(rst_n),
    .bus       (bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] fifo_q[$];
  logic [BW-1:0] got_q[$];
  logic [BW-1:0] exp_q[$];
  vec_t          vecs[15];

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [BW-1:0] beat,
                            input logic bvalid, input logic last,
                            input logic ack, input logic busy);
    check({name, ".beat"},  EW'(bus_if.beat_out),       EW'(beat));
    check({name, ".valid"}, EW'(bus_if.beat_valid_out), EW'(bvalid));
    check({name, ".last"},  EW'(bus_if.beat_last_out),  EW'(last));
    check({name, ".ack"},   EW'(bus_if.issue_ack_out),  EW'(ack));
    check({name, ".busy"},  EW'(bus_if.busy_out),       EW'(busy));
`ifdef SERIALIZER_BEAT_PARITY_EN
    check({name, ".parity"}, EW'(bus_if.beat_parity_out), EW'(^beat));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural FIFO head: present the oldest entry while one is queued.
  task automatic drive_from_fifo();
    if (fifo_q.size() != 0) begin
      bus_if.request_in       = fifo_q[0];
      bus_if.request_valid_in = 1'b1;
    end else begin
      bus_if.request_in       = '0;
      bus_if.request_valid_in = 1'b0;
    end
  endtask

  task automatic push_slices(input logic [EW-1:0] entry);
    for (int k = 0; k < NB; k++) exp_q.push_back(entry[k*BW +: BW]);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            acks;
    int            gaps;
    logic          prev_last;
    logic          found;
    logic [EW-1:0] ent_a, ent_b, ent_c, ent_d, ent_f;

    // ----- table: single entry, ignored request, backpressure --------------
    //              ready valid req      beat      vld last ack busy
    vecs[0]  = '{1'b1, 1'b1, ENTRY_E, 16'hCDEF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, ENTRY_X, 16'h89AB, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, ENTRY_X, 16'h4567, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, ENTRY_X, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, ENTRY_X, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, ENTRY_E, 16'hCDEF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 64'h0,   16'h89AB, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,   16'h89AB, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 64'h0,   16'h89AB, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,   16'h89AB, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 64'h0,   16'h4567, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 64'h0,   16'h0123, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 64'h0,   16'h0123, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 64'h0,   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 64'h0,   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    // ----- reset held with a valid entry present ----------------------------
    rst_n                   = 1'b0;
    bus_if.request_in       = ENTRY_E;
    bus_if.request_valid_in = 1'b1;
    bus_if.beat_ready_in    = 1'b1;
    #1;
    check_outs("rst.0", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_outs($sformatf("rst.%0d", i), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // ----- table (vec 0 is the first edge after release) --------------------
    for (int i = 0; i < 15; i++) begin
      bus_if.beat_ready_in    = vecs[i].ready;
      bus_if.request_valid_in = vecs[i].valid;
      bus_if.request_in       = vecs[i].req;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].beat, vecs[i].bvalid,
                 vecs[i].last, vecs[i].ack, vecs[i].busy);
    end

    // ----- back-to-back from a FIFO holding 3 entries -----------------------
    ent_a = 64'hA003_A002_A001_A000;
    ent_b = 64'hB003_B002_B001_B000;
    ent_c = 64'hC003_C002_C001_C000;
    fifo_q = {ent_a, ent_b, ent_c};
    exp_q.delete();
    got_q.delete();
    push_slices(ent_a);
    push_slices(ent_b);
    push_slices(ent_c);
    bus_if.beat_ready_in = 1'b1;
    acks      = 0;
    gaps      = 0;
    prev_last = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_from_fifo();
      tick();
      if (bus_if.issue_ack_out) begin
        acks++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (prev_last && !bus_if.beat_valid_out) gaps++;
      prev_last = bus_if.beat_valid_out & bus_if.beat_last_out;
      if (bus_if.beat_valid_out) got_q.push_back(bus_if.beat_out);
    end
    check("b2b.beats", EW'(got_q.size()), EW'(3 * NB));
    for (int k = 0; k < 3 * NB; k++) begin
      if (k < got_q.size())
        check($sformatf("b2b.beat%0d", k), EW'(got_q[k]), EW'(exp_q[k]));
    end
    check("b2b.acks", EW'(acks), EW'(3));
    check("b2b.fifo_empty", EW'(fifo_q.size()), EW'(0));
    check("b2b.gaps", EW'(gaps), EW'(3));

    // ----- reset after beat 1 of an entry is accepted -----------------------
    ent_d = 64'hD003_D002_D001_D000;
    ent_f = 64'hF003_F002_F001_F000;
    fifo_q = {ent_d, ent_f};
    acks   = 0;
    found  = 1'b0;
    for (int cyc = 0; cyc < 12 && !found; cyc++) begin
      drive_from_fifo();
      tick();
      if (bus_if.issue_ack_out) begin
        acks++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (bus_if.beat_valid_out && (bus_if.beat_out == ent_d[2*BW +: BW]))
        found = 1'b1;
    end
    check("mid.reached_beat2", EW'(found), EW'(1'b1));
    check("mid.acks_before", EW'(acks), EW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mid.rst_now", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_from_fifo();
    tick();
    check_outs("mid.rst_held", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    push_slices(ent_f);
    acks = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive_from_fifo();
      tick();
      if (cyc == 0) check_outs("mid.restart", 16'hF000, 1'b1, 1'b0, 1'b1, 1'b1);
      if (bus_if.issue_ack_out) begin
        acks++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (bus_if.beat_valid_out) got_q.push_back(bus_if.beat_out);
    end
    check("mid.beats", EW'(got_q.size()), EW'(NB));
    for (int k = 0; k < NB; k++) begin
      if (k < got_q.size())
        check($sformatf("mid.beat%0d", k), EW'(got_q[k]), EW'(exp_q[k]));
    end
    check("mid.acks_after", EW'(acks), EW'(1));
    check("mid.fifo_empty", EW'(fifo_q.size()), EW'(0));

`ifdef SERIALIZER_BEAT_PARITY_EN
    // ----- parity across the beats of 64'h0000_0000_0003_0001 --------------
    bus_if.beat_ready_in    = 1'b1;
    bus_if.request_valid_in = 1'b0;
    bus_if.request_in       = '0;
    #1;
    check("par.idle0", EW'(bus_if.beat_parity_out), EW'(1'b0));
    bus_if.request_in       = 64'h0000_0000_0003_0001;
    bus_if.request_valid_in = 1'b1;
    tick();
    check("par.beat0", EW'(bus_if.beat_parity_out), EW'(1'b1));
    bus_if.request_valid_in = 1'b0;
    tick();
    check("par.beat1", EW'(bus_if.beat_parity_out), EW'(1'b0));
    tick();
    check("par.beat2", EW'(bus_if.beat_parity_out), EW'(1'b0));
    tick();
    check("par.beat3", EW'(bus_if.beat_parity_out), EW'(1'b0));
    check("par.last3", EW'(bus_if.beat_last_out), EW'(1'b1));
    tick();
    check("par.idle1", EW'(bus_if.beat_parity_out), EW'(1'b0));
    check("par.idle1_valid", EW'(bus_if.beat_valid_out), EW'(1'b0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_request_serializer

// File: doc/fifo_request_serializer.md
# fifo_request_serializer

Consumer for the `fifo_queue` output handshake (`request_out`/`request_valid_out`/`issue_ack_in`). It pops one wide entry, acknowledges it with a single-cycle pulse, and replays the entry downstream as `NUM_BEATS` narrow beats on a valid/ready interface. It sits between a request FIFO and a narrow link or port, for example a 64-bit request queue feeding a 16-bit interconnect.

## Interface
- `SINGLE_ENTRY_WIDTH_IN_BITS`, 64, width of one popped entry.
- `BEAT_WIDTH_IN_BITS`, 16, width of one downstream beat; must divide `SINGLE_ENTRY_WIDTH_IN_BITS` exactly.
- `NUM_BEATS`, `SINGLE_ENTRY_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS`, beats per entry; must be ≥ 2.
- `BEAT_CNT_WIDTH_IN_BITS`, `$clog2(NUM_BEATS)`, beat counter width.

Ports:
- `clk_in`  in  1  single clock; all state on rising edge.
- `reset_n_in`  in  1  asynchronous, active-low reset.
- `request_in`  in  `SINGLE_ENTRY_WIDTH_IN_BITS`  entry from the FIFO's `request_out`.
- `request_valid_in`  in  1  from the FIFO's `request_valid_out`.
- `issue_ack_out`  out  1  to the FIFO's `issue_ack_in`; one-cycle pop pulse.
- `beat_out`  out  `BEAT_WIDTH_IN_BITS`  current beat, LSB slice first.
- `beat_valid_out`  out  1  beat valid.
- `beat_last_out`  out  1  high with the final beat of an entry.
- `beat_ready_in`  in  1  downstream accepts the beat.
- `busy_out`  out  1  an entry is held (state SEND).
- `beat_parity_out`  out  1  only present with `SERIALIZER_BEAT_PARITY_EN`.

## Operation
- Reset (`reset_n_in` low, takes effect immediately):
  - state IDLE, shift register 0, beat counter 0, holdoff 0.
  - All outputs 0.
  - Any held entry is discarded. It was already acked, so it is lost; this is intended.
- State IDLE:
  - Capture happens at the clock edge where `request_valid_in`=1 and holdoff=0.
  - On capture: load the shift register with `request_in`, clear the counter, move to SEND, set holdoff=2.
- `issue_ack_out` is registered and high for exactly the one cycle after a capture edge. There is never more than one pulse per entry.
- Holdoff:
  - Decrements once per cycle while nonzero.
  - It blocks capture during the ack cycle and the following cycle, which covers the FIFO's registered valid drop and re-present. This keeps an entry from being popped twice.
- State SEND:
  - `beat_valid_out`=1, `busy_out`=1.
  - `beat_out` = shift register bits [`BEAT_WIDTH_IN_BITS`-1:0].
  - `beat_last_out` = (counter == `NUM_BEATS`-1).
- Beat handshake (`beat_valid_out` & `beat_ready_in` at an edge):
  - Shift the register right by `BEAT_WIDTH_IN_BITS`, zero-filling the top; counter +1.
  - If the beat was last: counter back to 0, state IDLE, shift register cleared.
- With `beat_ready_in`=0, `beat_out`, `beat_last_out` and the counter hold. Valid is never withdrawn before acceptance.
- In IDLE, `beat_out`, `beat_valid_out` and `beat_last_out` are 0.
- `request_in` is ignored outside the capture edge.
- Beat order: beat k carries `request_in`[k·BW+BW-1 : k·BW], where BW = `BEAT_WIDTH_IN_BITS`.

## Timing
- Capture edge t. Ack high during cycle t+1. Beat 0 valid from cycle t+1.
- Beats are combinational from registers only, with no input-to-output paths. `beat_ready_in` affects state only.
- Minimum entry occupancy is `NUM_BEATS` cycles plus 1 IDLE cycle. Peak throughput is `NUM_BEATS` beats per `NUM_BEATS`+1 cycles.
- Holdoff expires by the end of cycle t+2, which is never later than the first possible IDLE cycle because `NUM_BEATS` ≥ 2.
- A beat handshake and a capture cannot occur in the same cycle, because capture happens only in IDLE.

## Configuration
- `SERIALIZER_BEAT_PARITY_EN` defined:
  - Adds port `beat_parity_out` = XOR reduction of `beat_out`, which is even parity.
  - It is 0 whenever `beat_valid_out`=0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `reset_n_in`=0 with `request_valid_in`=1 → all outputs 0, no ack. Release → capture on the first edge; ack on the next cycle only.
- Single entry 64'h0123_4567_89AB_CDEF, `beat_ready_in`=1:
  - Beats 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123 on 4 consecutive cycles, `beat_last_out` on the 4th only.
  - Exactly one `issue_ack_out` pulse, in the first beat cycle.
- Backpressure: drop `beat_ready_in` for 3 cycles while beat 1 is shown → `beat_out`=16'h89AB and `beat_valid_out`=1 held for all 3 cycles; beat 2 (16'h4567) follows on re-assertion.
- Back-to-back from a `fifo_queue` (QUEUE_SIZE 16) preloaded with 3 entries, ready always high:
  - 12 beats in order, exactly 3 ack pulses.
  - FIFO empty at the end, no duplicated entry, ≥1 idle cycle between entries.
- Reset mid-entry: assert `reset_n_in` after beat 1 is accepted → outputs 0 in the same cycle. After release, the next FIFO entry starts at beat 0 and the interrupted entry's remaining beats never appear.
- With `SERIALIZER_BEAT_PARITY_EN`: entry 64'h0000_0000_0003_0001 → parity 1, 0, 0, 0 across the 4 beats; `beat_parity_out` is 0 in IDLE.
